// File: rtl/game_sequencer.sv
// game_sequencer: timed LED-hit game FSM with scoring, countdown, random mole placement and WIN/LOSE display.
module game_sequencer #(
  parameter int GAME_SECS = 31,
  parameter int MOLE_CYCLES = 25000000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic [4:0] target,
  input  logic [9:0] key,
  output logic [9:0] led,
  output logic [4:0] score,
  output logic [4:0] time_left,
  output logic       busy,
  output logic       win,
  output logic       lose
);
  typedef enum logic [1:0] {IDLE, RUN, WIN, LOSE} state_t;
  localparam int TW = $clog2(MOLE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(MOLE_CYCLES - 1);
  localparam logic [4:0] SECS = 5'(GAME_SECS);
  state_t state, state_nx;
  logic start_q, start_evt, hit, miss, expire, enter_run, blink;
  logic [9:0] key_q, press, mole_oh;
  logic [7:0] lfsr;
  logic [3:0] mole_idx, cand, reloc;
  logic [TW-1:0] mole_t;
  logic [4:0] tgt, score_nx;
  assign start_evt = start & ~start_q;
  assign press = key & ~key_q;
  assign mole_oh = 10'd1 << mole_idx;
  assign hit = state == RUN && press == mole_oh;
  assign miss = state == RUN && press != 10'd0 && press != mole_oh;
  assign expire = mole_t == T_LAST;
  assign enter_run = start_evt && state != RUN;
  // Folding 10..15 back onto 0..5 keeps the candidate a valid LED index; bumping avoids a stationary mole.
  assign cand = lfsr[3:0] >= 4'd10 ? lfsr[3:0] - 4'd10 : lfsr[3:0];
  assign reloc = cand != mole_idx ? cand : cand == 4'd9 ? 4'd0 : cand + 4'd1;
  assign score_nx = hit ? (score == 5'd31 ? score : score + 5'd1) :
                    miss ? (score == 5'd0 ? score : score - 5'd1) : score;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Reaching the target wins even if the clock runs out on the same cycle.
  always_comb
    state_nx = state != RUN ? (start_evt ? RUN : state) :
               score_nx >= tgt ? WIN :
               (tick_1hz && time_left == 5'd0) ? LOSE : RUN;
  always_comb begin
    led = state == RUN ? mole_oh :
          (state == WIN || (state == LOSE && blink)) ? 10'h3FF : 10'h000;
    busy = state == RUN;
    win = state == WIN;
    lose = state == LOSE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= 1'b0;
      key_q <= 10'd0;
      lfsr <= LFSR_SEED;
      mole_idx <= 4'd0;
      mole_t <= '0;
      score <= 5'd0;
      time_left <= SECS;
      tgt <= 5'd1;
      blink <= 1'b0;
    end else begin
      start_q <= start;
      key_q <= key;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (enter_run) begin
        score <= 5'd0;
        time_left <= SECS;
        mole_t <= '0;
        mole_idx <= reloc;
        tgt <= target == 5'd0 ? 5'd1 : target;
      end else if (state == RUN) begin
        score <= score_nx;
        if (tick_1hz && time_left != 5'd0) time_left <= time_left - 5'd1;
        if (hit || expire) begin
          mole_idx <= reloc;
          mole_t <= '0;
        end else mole_t <= mole_t + TW'(1);
      end
      blink <= (state_nx == LOSE && state != LOSE) ? 1'b0 :
               (state == LOSE && tick_1hz) ? ~blink : blink;
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: randomized and directed checks of game_sequencer against a rule-level game model.
module tb_game_sequencer;
  localparam int MC = 8;
  logic clk = 0, rst = 0, tick_1hz = 0, start = 0;
  logic [4:0] target = 0;
  logic [9:0] key = 0;
  logic [9:0] led;
  logic [4:0] score, time_left;
  logic busy, win, lose;
  int errs = 0, checks = 0;
  int ms, msc, mtl, mtg, mmo, mti, mlf, mbl, msq, mkq;
  game_sequencer #(.GAME_SECS(31), .MOLE_CYCLES(MC), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start), .target(target), .key(key),
    .led(led), .score(score), .time_left(time_left), .busy(busy), .win(win), .lose(lose));
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    ms = 0; msc = 0; mtl = 31; mtg = 1; mmo = 0; mti = 0; mlf = 'hA5; mbl = 0; msq = 0; mkq = 0;
  endtask
  function automatic int exp_led();
    return ms == 1 ? (1 << mmo) : (ms == 2 || (ms == 3 && mbl != 0)) ? 'h3FF : 0;
  endfunction
  task automatic model_step();
    int se, pr, c, rl, ns, prev, hit, lose_now;
    se = (start && msq == 0) ? 1 : 0;
    pr = int'(key) & ~mkq & 'h3FF;
    c = mlf % 16;
    if (c >= 10) c -= 10;
    rl = (c == mmo) ? (c + 1) % 10 : c;
    prev = ms;
    if (ms != 1) begin
      if (se != 0) begin
        ms = 1; msc = 0; mtl = 31; mti = 0; mmo = rl;
        mtg = target == 0 ? 1 : int'(target);
      end
    end else begin
      hit = (pr == (1 << mmo)) ? 1 : 0;
      ns = hit != 0 ? (msc < 31 ? msc + 1 : 31) : pr != 0 ? (msc > 0 ? msc - 1 : 0) : msc;
      lose_now = (tick_1hz && mtl == 0) ? 1 : 0;
      if (tick_1hz && mtl > 0) mtl--;
      if (hit != 0 || mti == MC - 1) begin
        mmo = rl; mti = 0;
      end else mti++;
      msc = ns;
      if (ns >= mtg) ms = 2;
      else if (lose_now != 0) ms = 3;
    end
    if (ms == 3 && prev != 3) mbl = 0;
    else if (prev == 3 && tick_1hz) mbl ^= 1;
    mlf = ((mlf << 1) | (((mlf >> 7) ^ (mlf >> 5) ^ (mlf >> 4) ^ (mlf >> 3)) & 1)) & 255;
    msq = int'(start);
    mkq = int'(key);
  endtask
  task automatic check_outputs(string tag);
    chk({tag, "_led"}, int'(led), exp_led());
    chk({tag, "_score"}, int'(score), msc);
    chk({tag, "_time"}, int'(time_left), mtl);
    chk({tag, "_busy"}, int'(busy), ms == 1 ? 1 : 0);
    chk({tag, "_win"}, int'(win), ms == 2 ? 1 : 0);
    chk({tag, "_lose"}, int'(lose), ms == 3 ? 1 : 0);
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_time", int'(time_left), 31);
    chk("rst_flags", int'({busy, win, lose}), 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask
  task automatic pulse_start(int tg);
    target = 5'(tg);
    start = 1; step();
    start = 0; step();
  endtask
  task automatic hit_once();
    key = 10'(1 << mmo); step();
    key = 0; step();
  endtask
  task automatic tick_once();
    tick_1hz = 1; step();
    tick_1hz = 0; step();
  endtask
  initial begin
    int old, nmov, r;
    logic [9:0] prev_led;
    #2;
    do_reset();
    pulse_start(10);
    for (int i = 0; i < 3; i++) tick_once();
    do_reset();
    pulse_start(10);
    for (int i = 0; i < 10; i++) begin
      hit_once();
      chk("s2_score", int'(score), i + 1);
    end
    chk("s2_win", int'(win), 1);
    chk("s2_led", int'(led), 'h3FF);
    chk("s2_busy", int'(busy), 0);
    chk("s2_time", int'(time_left), 31);
    pulse_start(20);
    for (int i = 0; i < 31; i++) tick_once();
    chk("s3_time0", int'(time_left), 0);
    chk("s3_notlose", int'(lose), 0);
    tick_once();
    chk("s3_lose", int'(lose), 1);
    chk("s3_led_entry", int'(led), 0);
    tick_once(); chk("s3_blink1", int'(led), 'h3FF);
    tick_once(); chk("s3_blink2", int'(led), 0);
    tick_once(); chk("s3_blink3", int'(led), 'h3FF);
    pulse_start(20);
    key = 10'(1 << ((mmo + 1) % 10)); step(); key = 0; step();
    chk("s4_miss0", int'(score), 0);
    for (int i = 0; i < 3; i++) hit_once();
    chk("s4_three", int'(score), 3);
    key = 10'((1 << mmo) | (1 << ((mmo + 1) % 10))); step(); key = 0; step();
    chk("s4_multi", int'(score), 2);
    do_reset();
    pulse_start(15);
    for (int i = 0; i < 14; i++) hit_once();
    for (int i = 0; i < 31; i++) tick_once();
    chk("s5_score14", int'(score), 14);
    chk("s5_time0", int'(time_left), 0);
    key = 10'(1 << mmo); tick_1hz = 1; step();
    key = 0; tick_1hz = 0; step();
    chk("s5_win", int'(win), 1);
    chk("s5_lose", int'(lose), 0);
    chk("s5_score", int'(score), 15);
    do_reset();
    target = 31; start = 1; step(); start = 0;
    nmov = 0;
    for (int i = 0; i < 80; i++) begin
      old = mmo; prev_led = led;
      step();
      chk("s6_onehot", $countones(led), 1);
      if (mmo != old) begin
        nmov++;
        chk("s6_moved", (led != prev_led) ? 1 : 0, 1);
      end
    end
    chk("s6_moves", nmov, 10);
    key = 10'(1 << mmo);
    for (int i = 0; i < 5; i++) step();
    key = 0; step();
    chk("s6_hold", int'(score), 1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      start = ($urandom_range(0, 39) == 0);
      target = 5'($urandom_range(0, 31));
      tick_1hz = ($urandom_range(0, 6) == 0);
      r = $urandom_range(0, 9);
      key = r < 5 ? 10'd0 : r < 8 ? 10'(1 << mmo) : r == 8 ? 10'($urandom) : key;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
